// File: rtl/tmds_link_sequencer.sv
// tmds_link_sequencer
//  Brings the HDMI TMDS link up and down in order and is the only source of
//  serializer words for the three data channels and the clock channel.
//  Sequence: hot-plug debounce -> clock-only settle -> control preamble -> video.
//
//  Optional feature macro: TMDS_LINK_TEST_PATTERN_EN
//   Adds i_test_mode and parameter TEST_WORD; in ACTIVE with i_test_mode=1 the
//   three data words carry TEST_WORD and underflow is not flagged.
//
// Ports
//  i_pixclk      pixel clock, only clock
//  i_rst_n       asynchronous active-low reset
//  i_enable      link enable request (synchronous level)
//  i_hpd         hot-plug detect (asynchronous, synchronised inside)
//  i_*_word      TMDS-encoded words for channels 0..2
//  i_word_valid  encoder words valid this cycle
//  i_test_mode   (macro only) force TEST_WORD on data channels in ACTIVE
//  o_*_word      serializer words for data channels 0..2
//  o_clk_word    serializer word for the clock channel
//  o_oe          output buffer enable
//  o_link_up     high only in ACTIVE
//  o_underflow   sticky: invalid encoder word while ACTIVE
//  o_state       current state encoding

module tmds_link_sequencer #(
   parameter int unsigned HPD_DEBOUNCE  = 1024,
   parameter int unsigned CLK_SETTLE    = 256,
   parameter int unsigned CTRL_PREAMBLE = 64,
   parameter int unsigned CNT_W         = 16
`ifdef TMDS_LINK_TEST_PATTERN_EN
   ,
   parameter logic [9:0]  TEST_WORD     = 10'b1111100000
`endif
) (
   input  logic       i_pixclk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_hpd,
   input  logic [9:0] i_blue_word,
   input  logic [9:0] i_green_word,
   input  logic [9:0] i_red_word,
   input  logic       i_word_valid,
`ifdef TMDS_LINK_TEST_PATTERN_EN
   input  logic       i_test_mode,
`endif
   output logic [9:0] o_blue_word,
   output logic [9:0] o_green_word,
   output logic [9:0] o_red_word,
   output logic [9:0] o_clk_word,
   output logic       o_oe,
   output logic       o_link_up,
   output logic       o_underflow,
   output logic [2:0] o_state
);

   localparam logic [9:0] CTRL_00  = 10'b1101010100;
   localparam logic [9:0] CLK_PAT  = 10'b0000011111;
   localparam logic [9:0] CLK_IDLE = 10'b0000000000;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DEBOUNCE = 3'd1;
   localparam logic [2:0] ST_SETTLE   = 3'd2;
   localparam logic [2:0] ST_PREAMBLE = 3'd3;
   localparam logic [2:0] ST_ACTIVE   = 3'd4;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(HPD_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(CLK_SETTLE - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CTRL_PREAMBLE - 1);

   logic             hpd_meta_q, hpd_s_q;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       blue_q, blue_d;
   logic [9:0]       green_q, green_d;
   logic [9:0]       red_q, red_d;
   logic [9:0]       clk_word_q, clk_word_d;
   logic             oe_q, oe_d;
   logic             link_up_q, link_up_d;
   logic             underflow_q, underflow_d;
   logic             abort;
   logic             test_mode;

`ifdef TMDS_LINK_TEST_PATTERN_EN
   assign test_mode = i_test_mode;
`else
   assign test_mode = 1'b0;
`endif

   // Next state and phase counter. The counter is zero on every transition,
   // so each timed phase lasts exactly its parameter in cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      abort   = !i_enable || !hpd_s_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_DEBOUNCE;
            ST_DEBOUNCE: begin
               if (cnt_q == DEB_LAST) state_d = ST_SETTLE;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SETTLE: begin
               if (cnt_q == SET_LAST) state_d = ST_PREAMBLE;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_PREAMBLE: begin
               if (cnt_q == PRE_LAST) state_d = ST_ACTIVE;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change together with o_state.
   always_comb begin
      blue_d      = CTRL_00;
      green_d     = CTRL_00;
      red_d       = CTRL_00;
      clk_word_d  = CLK_IDLE;
      oe_d        = 1'b0;
      link_up_d   = 1'b0;
      underflow_d = underflow_q;
      if (state_d == ST_DEBOUNCE && state_q != ST_DEBOUNCE) underflow_d = 1'b0;
      case (state_d)
         ST_SETTLE, ST_PREAMBLE: begin
            oe_d       = 1'b1;
            clk_word_d = CLK_PAT;
         end
         ST_ACTIVE: begin
            oe_d       = 1'b1;
            link_up_d  = 1'b1;
            clk_word_d = CLK_PAT;
            if (test_mode) begin
`ifdef TMDS_LINK_TEST_PATTERN_EN
               blue_d  = TEST_WORD;
               green_d = TEST_WORD;
               red_d   = TEST_WORD;
`endif
            end else if (i_word_valid) begin
               blue_d  = i_blue_word;
               green_d = i_green_word;
               red_d   = i_red_word;
            end else if (state_q == ST_ACTIVE) begin
               // Only a starved cycle while already streaming counts as underflow.
               underflow_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_pixclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hpd_meta_q  <= 1'b0;
         hpd_s_q     <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         blue_q      <= CTRL_00;
         green_q     <= CTRL_00;
         red_q       <= CTRL_00;
         clk_word_q  <= CLK_IDLE;
         oe_q        <= 1'b0;
         link_up_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         hpd_meta_q  <= i_hpd;
         hpd_s_q     <= hpd_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blue_q      <= blue_d;
         green_q     <= green_d;
         red_q       <= red_d;
         clk_word_q  <= clk_word_d;
         oe_q        <= oe_d;
         link_up_q   <= link_up_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_blue_word  = blue_q;
   assign o_green_word = green_q;
   assign o_red_word   = red_q;
   assign o_clk_word   = clk_word_q;
   assign o_oe         = oe_q;
   assign o_link_up    = link_up_q;
   assign o_underflow  = underflow_q;
   assign o_state      = state_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bench for tmds_link_sequencer with short phase parameters
// (debounce 4, settle 3, preamble 2).

module tb_tmds_link_sequencer;

   localparam logic [9:0] CTRL_00  = 10'h354;
   localparam logic [9:0] CLK_PAT  = 10'h01F;
   localparam logic [9:0] CLK_IDLE = 10'h000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       hpd = 1'b0;
   logic [9:0] blue_in = '0, green_in = '0, red_in = '0;
   logic       valid = 1'b0;
`ifdef TMDS_LINK_TEST_PATTERN_EN
   logic       test_mode = 1'b0;
`endif
   logic [9:0] blue_out, green_out, red_out, clk_out;
   logic       oe, link_up, underflow;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   // State after each of the first 12 edges following reset release.
   int bring_exp [12] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 4};
   // States after edges E4..E11 of the hpd glitch scenario.
   int glitch_exp [8] = '{1, 1, 1, 1, 2, 2, 2, 3};

   always #5 clk = ~clk;

   tmds_link_sequencer #(
      .HPD_DEBOUNCE (4),
      .CLK_SETTLE   (3),
      .CTRL_PREAMBLE(2),
      .CNT_W        (16)
   ) dut (
      .i_pixclk    (clk),
      .i_rst_n     (rst_n),
      .i_enable    (enable),
      .i_hpd       (hpd),
      .i_blue_word (blue_in),
      .i_green_word(green_in),
      .i_red_word  (red_in),
      .i_word_valid(valid),
`ifdef TMDS_LINK_TEST_PATTERN_EN
      .i_test_mode (test_mode),
`endif
      .o_blue_word (blue_out),
      .o_green_word(green_out),
      .o_red_word  (red_out),
      .o_clk_word  (clk_out),
      .o_oe        (oe),
      .o_link_up   (link_up),
      .o_underflow (underflow),
      .o_state     (state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n  = 1'b0;
      enable = 1'b0;
      hpd    = 1'b1;
      tick();
      total++;
      if ({state, oe, link_up, underflow} !== 6'b000_000 || clk_out !== CLK_IDLE ||
          blue_out !== CTRL_00 || green_out !== CTRL_00 || red_out !== CTRL_00) begin
         bad++;
         $display("FAIL reset_values: state=%0d oe=%b lu=%b uf=%b clk=%h b=%h g=%h r=%h",
                  state, oe, link_up, underflow, clk_out, blue_out, green_out, red_out);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      total++;
      if (state !== 3'd0 || oe !== 1'b0 || clk_out !== CLK_IDLE || blue_out !== CTRL_00 ||
          green_out !== CTRL_00 || red_out !== CTRL_00) begin
         bad++;
         $display("FAIL disabled_idle: state=%0d oe=%b clk=%h b=%h want state=0 oe=0 clk=0 b=354",
                  state, oe, clk_out, blue_out);
      end
   endtask

   task automatic test_bringup;
      tick();
      rst_n    = 1'b0;
      enable   = 1'b1;
      hpd      = 1'b1;
      valid    = 1'b1;
      blue_in  = 10'h2AB;
      green_in = 10'h155;
      red_in   = 10'h0F0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         total++;
         if (state !== 3'(bring_exp[i]) || oe !== (bring_exp[i] >= 2) ||
             link_up !== (bring_exp[i] == 4) ||
             clk_out !== ((bring_exp[i] >= 2) ? CLK_PAT : CLK_IDLE)) begin
            bad++;
            $display("FAIL bringup_edge%0d: state=%0d oe=%b lu=%b clk=%h want state=%0d",
                     i + 1, state, oe, link_up, clk_out, bring_exp[i]);
         end
         if (bring_exp[i] < 4) begin
            total++;
            if (blue_out !== CTRL_00 || green_out !== CTRL_00 || red_out !== CTRL_00) begin
               bad++;
               $display("FAIL bringup_data%0d: b=%h g=%h r=%h want 354", i + 1, blue_out,
                        green_out, red_out);
            end
         end
      end
      total++;
      if (blue_out !== 10'h2AB || green_out !== 10'h155 || red_out !== 10'h0F0 ||
          underflow !== 1'b0) begin
         bad++;
         $display("FAIL first_active_word: b=%h g=%h r=%h uf=%b want 2ab 155 0f0 0", blue_out,
                  green_out, red_out, underflow);
      end
   endtask

   task automatic test_active_data;
      blue_in = 10'h3C3;
      tick();
      total++;
      if (blue_out !== 10'h3C3 || green_out !== 10'h155 || link_up !== 1'b1) begin
         bad++;
         $display("FAIL pass_through: b=%h g=%h lu=%b want 3c3 155 1", blue_out, green_out,
                  link_up);
      end
      valid = 1'b0;
      tick();
      total++;
      if (blue_out !== CTRL_00 || green_out !== CTRL_00 || red_out !== CTRL_00 ||
          underflow !== 1'b1 || state !== 3'd4) begin
         bad++;
         $display("FAIL underflow: b=%h g=%h r=%h uf=%b state=%0d want 354 x3 uf=1 state=4",
                  blue_out, green_out, red_out, underflow, state);
      end
      valid   = 1'b1;
      blue_in = 10'h111;
      tick();
      total++;
      if (blue_out !== 10'h111 || underflow !== 1'b1 || clk_out !== CLK_PAT) begin
         bad++;
         $display("FAIL underflow_sticky: b=%h uf=%b clk=%h want 111 1 01f", blue_out,
                  underflow, clk_out);
      end
   endtask

   task automatic test_enable_drop;
      enable = 1'b0;
      tick();
      total++;
      if (state !== 3'd0 || oe !== 1'b0 || link_up !== 1'b0 || clk_out !== CLK_IDLE ||
          blue_out !== CTRL_00 || underflow !== 1'b1) begin
         bad++;
         $display("FAIL enable_drop: state=%0d oe=%b lu=%b clk=%h b=%h uf=%b want 0 0 0 0 354 1",
                  state, oe, link_up, clk_out, blue_out, underflow);
      end
      enable = 1'b1;
      tick();
      total++;
      if (state !== 3'd1 || underflow !== 1'b0 || oe !== 1'b0) begin
         bad++;
         $display("FAIL debounce_entry: state=%0d uf=%b oe=%b want 1 0 0", state, underflow, oe);
      end
   endtask

   task automatic test_hpd_glitch;
      hpd = 1'b0;
      tick();
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL glitch_e1: state=%0d want 1", state);
      end
      hpd = 1'b1;
      tick();
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL glitch_e2: state=%0d want 1", state);
      end
      tick();
      total++;
      if (state !== 3'd0 || oe !== 1'b0) begin
         bad++;
         $display("FAIL glitch_abort: state=%0d oe=%b want 0 0", state, oe);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (state !== 3'(glitch_exp[i])) begin
            bad++;
            $display("FAIL glitch_restart%0d: state=%0d want %0d", i, state, glitch_exp[i]);
         end
      end
   endtask

   task automatic test_reset_preamble;
      rst_n = 1'b0;
      #1;
      total++;
      if (state !== 3'd0 || oe !== 1'b0 || link_up !== 1'b0 || underflow !== 1'b0 ||
          clk_out !== CLK_IDLE || blue_out !== CTRL_00 || red_out !== CTRL_00) begin
         bad++;
         $display("FAIL async_reset: state=%0d oe=%b lu=%b uf=%b clk=%h b=%h r=%h", state, oe,
                  link_up, underflow, clk_out, blue_out, red_out);
      end
   endtask

   task automatic test_both_drop;
      enable = 1'b0;
      hpd    = 1'b0;
      tick();
      total++;
      if (state !== 3'd0 || oe !== 1'b0 || link_up !== 1'b0) begin
         bad++;
         $display("FAIL both_drop: state=%0d oe=%b lu=%b want 0 0 0", state, oe, link_up);
      end
      tick();
      tick();
      total++;
      if (state !== 3'd0) begin
         bad++;
         $display("FAIL both_drop_hold: state=%0d want 0", state);
      end
      enable = 1'b1;
      hpd    = 1'b1;
      tick();
      tick();
      total++;
      if (state !== 3'd0) begin
         bad++;
         $display("FAIL hpd_sync_delay: state=%0d want 0", state);
      end
      tick();
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL hpd_sync_entry: state=%0d want 1", state);
      end
   endtask

`ifdef TMDS_LINK_TEST_PATTERN_EN
   task automatic test_pattern;
      test_mode = 1'b1;
      valid     = 1'b0;
      tick();
      total++;
      if (blue_out !== 10'h3E0 || green_out !== 10'h3E0 || red_out !== 10'h3E0 ||
          underflow !== 1'b0) begin
         bad++;
         $display("FAIL test_pattern: b=%h g=%h r=%h uf=%b want 3e0 x3 uf=0", blue_out,
                  green_out, red_out, underflow);
      end
      test_mode = 1'b0;
      valid     = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_bringup();
      test_active_data();
      test_enable_drop();
      test_hpd_glitch();
      test_reset_preamble();
      test_bringup();
      test_both_drop();
`ifdef TMDS_LINK_TEST_PATTERN_EN
      test_bringup();
      test_pattern();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1);
   end

endmodule
